// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the envelope / mixer datapath.
//   env_state_t    : per-voice envelope phase
//   mix_state_t    : mixer sequencing phase
//   SILENCE_OFFSET : offset-binary code for a zero-amplitude output sample
// -----------------------------------------------------------------------------
package audio_pkg;

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_ACCUM,
        M_OUT
    } mix_state_t;

    localparam logic [15:0] SILENCE_OFFSET = 16'h8000;

endpackage

// File: rtl/envelope_gen.sv
// -----------------------------------------------------------------------------
// envelope_gen
// One voice's attack/sustain/release envelope. The level only moves on cycles
// where tick_in is high.
//   clk_in     : system clock
//   rst_in     : asynchronous active-low reset
//   tick_in    : sample-rate strobe
//   gate_in    : key held for this voice
//   env_out    : current envelope level (0 .. 2**ENV_WIDTH-1)
//   active_out : registered (env_out != 0)
// -----------------------------------------------------------------------------
module envelope_gen
    import audio_pkg::*;
#(
    parameter int ENV_WIDTH    = 8,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 tick_in,
    input  logic                 gate_in,
    output logic [ENV_WIDTH-1:0] env_out,
    output logic                 active_out
);

    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

    env_state_t           state_q, state_d;
    logic [ENV_WIDTH-1:0] env_q, env_d;
    logic                 active_q;

    // One extra bit on the sum so the attack step cannot wrap past ENV_MAX.
    logic [ENV_WIDTH:0]   env_sum;
    logic [ENV_WIDTH-1:0] env_up;
    logic [ENV_WIDTH-1:0] env_dn;

    assign env_sum = {1'b0, env_q} + (ENV_WIDTH+1)'(ATTACK_STEP);
    assign env_up  = (env_sum >= {1'b0, ENV_MAX}) ? ENV_MAX : env_sum[ENV_WIDTH-1:0];
    assign env_dn  = (env_q <= ENV_WIDTH'(RELEASE_STEP)) ? '0
                                                         : env_q - ENV_WIDTH'(RELEASE_STEP);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= ENV_IDLE;
            env_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            active_q <= (env_d != '0);
        end
    end

    // A phase change takes effect on the same tick: the new phase's step is
    // applied immediately, so a retrigger from release climbs from the current
    // level and a key release starts decaying at once.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (tick_in) begin
            case (state_q)
                ENV_IDLE: begin
                    if (gate_in) begin
                        env_d   = env_up;
                        state_d = (env_up == ENV_MAX) ? ENV_SUSTAIN : ENV_ATTACK;
                    end
                end
                ENV_ATTACK, ENV_RELEASE: begin
                    if (gate_in) begin
                        env_d   = env_up;
                        state_d = (env_up == ENV_MAX) ? ENV_SUSTAIN : ENV_ATTACK;
                    end else begin
                        env_d   = env_dn;
                        state_d = (env_dn == '0) ? ENV_IDLE : ENV_RELEASE;
                    end
                end
                ENV_SUSTAIN: begin
                    if (!gate_in) begin
                        env_d   = env_dn;
                        state_d = (env_dn == '0) ? ENV_IDLE : ENV_RELEASE;
                    end
                end
                default: begin
                    state_d = ENV_IDLE;
                    env_d   = '0;
                end
            endcase
        end
    end

    assign env_out    = env_q;
    assign active_out = active_q;

endmodule

// File: rtl/envelope_mixer.sv
// -----------------------------------------------------------------------------
// envelope_mixer
// Per-voice envelopes plus a serial polyphonic mixer. On an accepted sample
// tick the voice samples are snapshotted, then one voice per cycle is scaled
// by its envelope and accumulated. The sum is shifted, saturated and emitted
// as an offset-binary word.
//   clk_in         : system clock
//   rst_in         : asynchronous active-low reset
//   sample_tick_in : 1-cycle sample-rate strobe
//   gate_in        : per-voice key held
//   sample_in      : per-voice signed sample
//   dc_out         : offset-binary mix, SILENCE_OFFSET = silence
//   dc_valid_out   : 1-cycle pulse when dc_out updates
//   active_out     : per-voice envelope != 0
//   busy_out       : mixer sequence in progress
//   overrun_out    : sticky, a tick arrived while busy
// -----------------------------------------------------------------------------
module envelope_mixer
    import audio_pkg::*;
#(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ENV_WIDTH    = 8,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 2,
    parameter int MIX_SHIFT    = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sample_tick_in,
    input  logic [NUM_VOICES-1:0]          gate_in,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in [NUM_VOICES],
    output logic [SAMPLE_WIDTH-1:0]        dc_out,
    output logic                           dc_valid_out,
    output logic [NUM_VOICES-1:0]          active_out,
    output logic                           busy_out,
    output logic                           overrun_out
);

    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_WIDTH + $clog2(NUM_VOICES) + 1;
    localparam int PROD_W = SAMPLE_WIDTH + ENV_WIDTH + 1;
    localparam int SAT_MAX_I = 2**(SAMPLE_WIDTH-1) - 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(SAT_MAX_I);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-SAT_MAX_I - 1);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [SAMPLE_WIDTH-1:0] DC_SILENCE = SAMPLE_WIDTH'(SILENCE_OFFSET);

    // ------------------------------------------------------------------
    // Envelopes
    // ------------------------------------------------------------------
    logic [ENV_WIDTH-1:0] env [NUM_VOICES];

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            envelope_gen #(
                .ENV_WIDTH    (ENV_WIDTH),
                .ATTACK_STEP  (ATTACK_STEP),
                .RELEASE_STEP (RELEASE_STEP)
            ) u_env (
                .clk_in     (clk_in),
                .rst_in     (rst_in),
                .tick_in    (sample_tick_in),
                .gate_in    (gate_in[gi]),
                .env_out    (env[gi]),
                .active_out (active_out[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Mixer state
    // ------------------------------------------------------------------
    mix_state_t                     mstate_q, mstate_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [SAMPLE_WIDTH-1:0]        dc_q, dc_d;
    logic                           dc_valid_q, dc_valid_d;
    logic                           overrun_q, overrun_d;
    logic signed [SAMPLE_WIDTH-1:0] snap_q [NUM_VOICES];

    logic                           accept;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        voice_term;
    logic signed [ACC_W-1:0]        mix_shifted;
    logic [SAMPLE_WIDTH-1:0]        mix_sat;

    assign accept = sample_tick_in && (mstate_q == M_IDLE);

    // Envelope is zero-extended so the multiply stays signed x unsigned. The
    // envelope is read live: the tick edge has already updated it.
    assign prod       = snap_q[idx_q] * $signed({1'b0, env[idx_q]});
    // After the shift the value fits in SAMPLE_WIDTH+1 bits; the narrowing
    // only drops sign copies.
    assign voice_term = ACC_W'(prod >>> ENV_WIDTH);

    assign mix_shifted = acc_q >>> MIX_SHIFT;
    always_comb begin
        if (mix_shifted > SAT_MAX) begin
            mix_sat = SAT_MAX[SAMPLE_WIDTH-1:0];
        end else if (mix_shifted < SAT_MIN) begin
            mix_sat = SAT_MIN[SAMPLE_WIDTH-1:0];
        end else begin
            mix_sat = mix_shifted[SAMPLE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                snap_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                snap_q[k] <= sample_in[k];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mstate_q   <= M_IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            dc_q       <= DC_SILENCE;
            dc_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            mstate_q   <= mstate_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            dc_q       <= dc_d;
            dc_valid_q <= dc_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        mstate_d   = mstate_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        dc_d       = dc_q;
        dc_valid_d = 1'b0;
        overrun_d  = overrun_q;

        case (mstate_q)
            M_IDLE: begin
                if (sample_tick_in) begin
                    mstate_d = M_ACCUM;
                    idx_d    = '0;
                    acc_d    = '0;
                end
            end
            M_ACCUM: begin
                acc_d = acc_q + voice_term;
                if (idx_q == LAST_IDX) begin
                    mstate_d = M_OUT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            M_OUT: begin
                // Two's complement to offset binary: flip the sign bit.
                dc_d       = {~mix_sat[SAMPLE_WIDTH-1], mix_sat[SAMPLE_WIDTH-2:0]};
                dc_valid_d = 1'b1;
                mstate_d   = M_IDLE;
            end
            default: begin
                mstate_d = M_IDLE;
            end
        endcase

        // A tick during a sequence is dropped by the mixer but remembered.
        if (sample_tick_in && (mstate_q != M_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    assign dc_out       = dc_q;
    assign dc_valid_out = dc_valid_q;
    assign busy_out     = (mstate_q != M_IDLE);
    assign overrun_out  = overrun_q;

endmodule

// File: tb/tb_envelope_mixer.sv
module tb_envelope_mixer;

    localparam int NV = 8;
    localparam int SW = 16;
    localparam int ENV_MAX_M = 255;
    localparam int ATK = 4;
    localparam int REL = 2;
    localparam int SHIFT_DIV = 4;   // 2**MIX_SHIFT
    localparam int ENV_DIV = 256;   // 2**ENV_WIDTH

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                  rst_in;
    logic                  sample_tick_in;
    logic [NV-1:0]         gate_in;
    logic signed [SW-1:0]  sample_in [NV];
    logic [SW-1:0]         dc_out;
    logic                  dc_valid_out;
    logic [NV-1:0]         active_out;
    logic                  busy_out;
    logic                  overrun_out;

    int compared = 0;
    int mismatched = 0;

    // Reference state: one envelope level per voice, and the samples the
    // next tick will present.
    int                   env_m [NV];
    logic signed [SW-1:0] samp_set [NV];

    envelope_mixer dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .sample_tick_in (sample_tick_in),
        .gate_in        (gate_in),
        .sample_in      (sample_in),
        .dc_out         (dc_out),
        .dc_valid_out   (dc_valid_out),
        .active_out     (active_out),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Key held: climb toward full scale. Key released: decay toward zero.
    function automatic void ref_env_step();
        for (int k = 0; k < NV; k++) begin
            if (gate_in[k]) env_m[k] = (env_m[k] + ATK > ENV_MAX_M) ? ENV_MAX_M : env_m[k] + ATK;
            else            env_m[k] = (env_m[k] < REL) ? 0 : env_m[k] - REL;
        end
    endfunction

    function automatic logic [SW-1:0] ref_mix();
        longint acc;
        longint m;
        acc = 0;
        for (int k = 0; k < NV; k++) begin
            acc += floor_div(longint'(samp_set[k]) * env_m[k], ENV_DIV);
        end
        m = floor_div(acc, SHIFT_DIV);
        if (m > 32767)  m = 32767;
        if (m < -32768) m = -32768;
        return 16'(m) ^ 16'h8000;
    endfunction

    function automatic logic [NV-1:0] ref_active();
        logic [NV-1:0] a;
        for (int k = 0; k < NV; k++) a[k] = (env_m[k] != 0);
        return a;
    endfunction

    // Issues one tick and waits for the resulting dc_valid_out. Returns the
    // latency in cycles (counted from the tick cycle) and the model's view.
    task automatic do_tick(input bit now, output int lat, output logic [SW-1:0] exp_dc,
                           output logic [NV-1:0] exp_act, output logic busy_seen);
        if (!now) @(negedge clk_in);
        for (int k = 0; k < NV; k++) sample_in[k] = samp_set[k];
        sample_tick_in = 1'b1;
        ref_env_step();
        exp_dc  = ref_mix();
        exp_act = ref_active();
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        busy_seen = busy_out;
        // Scramble inputs: the mix must come from the snapshot.
        for (int k = 0; k < NV; k++) sample_in[k] = SW'($urandom);
        lat = 1;
        while (dc_valid_out !== 1'b1 && lat < 20) begin
            @(negedge clk_in);
            lat++;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_in = 1'b0;
        sample_tick_in = 1'b0;
        gate_in = '0;
        for (int k = 0; k < NV; k++) begin
            sample_in[k] = '0;
            samp_set[k]  = '0;
            env_m[k]     = 0;
        end
        repeat (4) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        $display("reset: dc=%h valid=%b busy=%b overrun=%b active=%b",
                 dc_out, dc_valid_out, busy_out, overrun_out, active_out);
        compared++; if (dc_out !== 16'h8000) begin mismatched++; $display("FAIL reset_dc: got %h expected 8000", dc_out); end
        compared++; if (dc_valid_out !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", dc_valid_out); end
        compared++; if (busy_out !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
        compared++; if (overrun_out !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b expected 0", overrun_out); end
        compared++; if (active_out !== '0) begin mismatched++; $display("FAIL reset_active: got %b expected 0", active_out); end
    endtask

    task automatic test_single_voice();
        int lat; logic [SW-1:0] exp_dc; logic [NV-1:0] exp_act; logic bz;
        gate_in = 8'h01;
        samp_set[0] = 16'sh4000;
        for (int k = 1; k < NV; k++) samp_set[k] = SW'($urandom);
        for (int i = 0; i < 64; i++) begin
            do_tick(1'b0, lat, exp_dc, exp_act, bz);
            $display("single tick %0d: dc=%h exp=%h lat=%0d act=%b", i, dc_out, exp_dc, lat, active_out);
            compared++; if (lat != 10) begin mismatched++; $display("FAIL single_latency: got %0d expected 10", lat); end
            compared++; if (dc_out !== exp_dc) begin mismatched++; $display("FAIL single_dc: got %h expected %h", dc_out, exp_dc); end
            compared++; if (active_out !== exp_act) begin mismatched++; $display("FAIL single_active: got %b expected %b", active_out, exp_act); end
            compared++; if (bz !== 1'b1) begin mismatched++; $display("FAIL single_busy: got %b expected 1", bz); end
        end
        compared++; if (dc_out !== 16'h8FF0) begin mismatched++; $display("FAIL single_final_dc: got %h expected 8ff0", dc_out); end
    endtask

    task automatic test_release();
        int lat; logic [SW-1:0] exp_dc; logic [NV-1:0] exp_act; logic bz;
        int fall_tick;
        fall_tick = -1;
        gate_in = 8'h00;
        for (int i = 1; i <= 140; i++) begin
            do_tick(1'b0, lat, exp_dc, exp_act, bz);
            $display("release tick %0d: dc=%h exp=%h act=%b", i, dc_out, exp_dc, active_out);
            compared++; if (dc_out !== exp_dc) begin mismatched++; $display("FAIL release_dc: got %h expected %h", dc_out, exp_dc); end
            if (fall_tick < 0 && active_out[0] === 1'b0) fall_tick = i;
        end
        compared++; if (fall_tick != 128) begin mismatched++; $display("FAIL release_fall_tick: got %0d expected 128", fall_tick); end
    endtask

    task automatic test_retrigger();
        int lat; logic [SW-1:0] exp_dc; logic [NV-1:0] exp_act; logic bz;
        gate_in = 8'h01;
        repeat (26) do_tick(1'b0, lat, exp_dc, exp_act, bz);
        gate_in = 8'h00;
        repeat (2) do_tick(1'b0, lat, exp_dc, exp_act, bz);
        $display("retrigger at 100: dc=%h", dc_out);
        compared++; if (dc_out !== 16'h8640) begin mismatched++; $display("FAIL retrig_env100: got %h expected 8640", dc_out); end
        gate_in = 8'h01;
        do_tick(1'b0, lat, exp_dc, exp_act, bz);
        $display("retrigger next: dc=%h exp=%h", dc_out, exp_dc);
        compared++; if (dc_out !== 16'h8680) begin mismatched++; $display("FAIL retrig_env104: got %h expected 8680", dc_out); end
        compared++; if (dc_out !== exp_dc) begin mismatched++; $display("FAIL retrig_model: got %h expected %h", dc_out, exp_dc); end
    endtask

    task automatic test_saturation();
        int lat; logic [SW-1:0] exp_dc; logic [NV-1:0] exp_act; logic bz;
        gate_in = 8'hFF;
        for (int k = 0; k < NV; k++) samp_set[k] = 16'sh7FFF;
        for (int i = 0; i < 64; i++) begin
            do_tick(1'b0, lat, exp_dc, exp_act, bz);
            $display("sat+ tick %0d: dc=%h exp=%h", i, dc_out, exp_dc);
            compared++; if (dc_out !== exp_dc) begin mismatched++; $display("FAIL satpos_dc: got %h expected %h", dc_out, exp_dc); end
        end
        compared++; if (dc_out !== 16'hFFFF) begin mismatched++; $display("FAIL satpos_final: got %h expected ffff", dc_out); end
        for (int k = 0; k < NV; k++) samp_set[k] = 16'sh8000;
        do_tick(1'b0, lat, exp_dc, exp_act, bz);
        $display("sat- tick: dc=%h exp=%h", dc_out, exp_dc);
        compared++; if (dc_out !== 16'h0000) begin mismatched++; $display("FAIL satneg_final: got %h expected 0000", dc_out); end
    endtask

    task automatic test_random();
        int lat; logic [SW-1:0] exp_dc; logic [NV-1:0] exp_act; logic bz;
        for (int i = 0; i < 40; i++) begin
            gate_in = NV'($urandom);
            for (int k = 0; k < NV; k++) samp_set[k] = SW'($urandom);
            do_tick(1'b0, lat, exp_dc, exp_act, bz);
            $display("random tick %0d: gate=%b dc=%h exp=%h act=%b", i, gate_in, dc_out, exp_dc, active_out);
            compared++; if (dc_out !== exp_dc) begin mismatched++; $display("FAIL random_dc: got %h expected %h", dc_out, exp_dc); end
            compared++; if (active_out !== exp_act) begin mismatched++; $display("FAIL random_active: got %b expected %b", active_out, exp_act); end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [SW-1:0] exp_dc; logic [NV-1:0] exp_act; logic bz;
        gate_in = NV'($urandom);
        for (int k = 0; k < NV; k++) samp_set[k] = SW'($urandom);
        do_tick(1'b0, lat, exp_dc, exp_act, bz);
        // Next tick lands in the very cycle dc_valid_out is high.
        for (int k = 0; k < NV; k++) samp_set[k] = SW'($urandom);
        do_tick(1'b1, lat, exp_dc, exp_act, bz);
        $display("back_to_back: dc=%h exp=%h lat=%0d overrun=%b", dc_out, exp_dc, lat, overrun_out);
        compared++; if (lat != 10) begin mismatched++; $display("FAIL b2b_latency: got %0d expected 10", lat); end
        compared++; if (dc_out !== exp_dc) begin mismatched++; $display("FAIL b2b_dc: got %h expected %h", dc_out, exp_dc); end
        compared++; if (overrun_out !== 1'b0) begin mismatched++; $display("FAIL b2b_overrun: got %b expected 0", overrun_out); end
    endtask

    task automatic test_overrun();
        int pulses; int lat; logic [SW-1:0] exp_dc; logic [NV-1:0] exp_act; logic bz;
        gate_in = NV'($urandom);
        @(negedge clk_in);
        sample_tick_in = 1'b1; ref_env_step();
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        pulses = 0;
        repeat (2) begin @(negedge clk_in); if (dc_valid_out === 1'b1) pulses++; end
        sample_tick_in = 1'b1; ref_env_step();
        for (int c = 0; c < 25; c++) begin
            @(negedge clk_in);
            sample_tick_in = 1'b0;
            if (dc_valid_out === 1'b1) pulses++;
        end
        $display("overrun: pulses=%0d overrun=%b", pulses, overrun_out);
        compared++; if (pulses != 1) begin mismatched++; $display("FAIL overrun_pulses: got %0d expected 1", pulses); end
        compared++; if (overrun_out !== 1'b1) begin mismatched++; $display("FAIL overrun_flag: got %b expected 1", overrun_out); end
        // Envelopes advanced on both ticks; the next normal tick must agree.
        for (int k = 0; k < NV; k++) samp_set[k] = SW'($urandom);
        do_tick(1'b0, lat, exp_dc, exp_act, bz);
        $display("post-overrun tick: dc=%h exp=%h overrun=%b", dc_out, exp_dc, overrun_out);
        compared++; if (dc_out !== exp_dc) begin mismatched++; $display("FAIL postovr_dc: got %h expected %h", dc_out, exp_dc); end
        compared++; if (overrun_out !== 1'b1) begin mismatched++; $display("FAIL overrun_sticky: got %b expected 1", overrun_out); end
    endtask

    task automatic test_reset_mid();
        int pulses; int lat; logic [SW-1:0] exp_dc; logic [NV-1:0] exp_act; logic bz;
        gate_in = 8'hFF;
        @(negedge clk_in);
        sample_tick_in = 1'b1; ref_env_step();
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        for (int k = 0; k < NV; k++) env_m[k] = 0;
        $display("reset mid: dc=%h valid=%b busy=%b overrun=%b active=%b",
                 dc_out, dc_valid_out, busy_out, overrun_out, active_out);
        compared++; if (dc_out !== 16'h8000) begin mismatched++; $display("FAIL rstmid_dc: got %h expected 8000", dc_out); end
        compared++; if (busy_out !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy: got %b expected 0", busy_out); end
        compared++; if (overrun_out !== 1'b0) begin mismatched++; $display("FAIL rstmid_overrun: got %b expected 0", overrun_out); end
        compared++; if (active_out !== '0) begin mismatched++; $display("FAIL rstmid_active: got %b expected 0", active_out); end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            if (dc_valid_out === 1'b1) pulses++;
        end
        compared++; if (pulses != 0) begin mismatched++; $display("FAIL rstmid_pulses: got %0d expected 0", pulses); end
        for (int k = 0; k < NV; k++) samp_set[k] = SW'($urandom);
        do_tick(1'b0, lat, exp_dc, exp_act, bz);
        $display("post-reset tick: dc=%h exp=%h lat=%0d", dc_out, exp_dc, lat);
        compared++; if (dc_out !== exp_dc) begin mismatched++; $display("FAIL postrst_dc: got %h expected %h", dc_out, exp_dc); end
    endtask

    initial begin
        test_reset();
        test_single_voice();
        test_release();
        test_retrigger();
        test_saturation();
        test_random();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
